// File: rtl/roi_scan_ctrl.sv
// Serial scan controller for CLB minitests: deserialises a din vector, drives it to the ROI,
// waits a settle time, captures dout and serialises it back out MSB first.
module roi_scan_ctrl #(
    parameter int DIN_N  = 256,
    parameter int DOUT_N = 256,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              di,
    output logic [DIN_N-1:0]  din,
    input  logic [DOUT_N-1:0] dout,
    output logic              so,
    output logic              so_valid,
    output logic              busy,
    output logic              done
);

    localparam int MAX_IO = (DIN_N > DOUT_N) ? DIN_N : DOUT_N;
    localparam int MAX_N  = (MAX_IO > SETTLE) ? MAX_IO : SETTLE;
    localparam int CW     = $clog2(MAX_N + 1);
    localparam logic [CW-1:0] IN_LAST   = CW'(DIN_N - 1);
    localparam logic [CW-1:0] OUT_LAST  = CW'(DOUT_N - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);

    typedef enum logic [2:0] {
        IDLE, SHIFT_IN, LOAD, WAIT, CAPTURE, SHIFT_OUT, DONE
    } state_t;

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [DIN_N-1:0]  din_shr;
    logic [DOUT_N-1:0] dout_shr;
    logic              shift_in, load, capture, shift_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            din      <= '0;
            din_shr  <= '0;
            dout_shr <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (shift_in) din_shr <= {din_shr[DIN_N-2:0], di};
            if (load)     din     <= din_shr;
            if (capture)
                dout_shr <= dout;
            else if (shift_out)
                dout_shr <= {dout_shr[DOUT_N-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        shift_in  = 1'b0;
        load      = 1'b0;
        capture   = 1'b0;
        shift_out = 1'b0;
        busy      = (state != IDLE);
        done      = (state == DONE);
        so_valid  = (state == SHIFT_OUT);
        so        = (state == SHIFT_OUT) & dout_shr[DOUT_N-1];
        // Abort wins over everything, including the LOAD strobe, so din stays put.
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state_d = SHIFT_IN;
                    cnt_d   = '0;
                end
                SHIFT_IN: begin
                    shift_in = 1'b1;
                    if (cnt == IN_LAST) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                    end else cnt_d = cnt + CW'(1);
                end
                LOAD: begin
                    load    = 1'b1;
                    state_d = (SETTLE == 0) ? CAPTURE : WAIT;
                end
                WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        state_d = CAPTURE;
                        cnt_d   = '0;
                    end else cnt_d = cnt + CW'(1);
                end
                CAPTURE: begin
                    capture = 1'b1;
                    state_d = SHIFT_OUT;
                end
                SHIFT_OUT: begin
                    shift_out = 1'b1;
                    if (cnt == OUT_LAST) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else cnt_d = cnt + CW'(1);
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

endmodule
